// File: rtl/minifloat_accum.sv
// Frame accumulator for 7-bit minifloat codes (3-bit exponent, 4-bit mantissa).
// Decodes each accepted code, sums a frame with saturation, hands the result downstream.
module minifloat_accum #(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [8:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [8:0] LAST = 9'(FRAME_LEN);

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [8:0]       cnt;
    logic             ovf;

    logic [10:0]      value;
    logic [SUM_W:0]   sum_ext;
    logic             carry;
    logic [SUM_W-1:0] acc_next;
    logic [8:0]       cnt_next;
    logic             ovf_next;
    logic             accept;
    logic             close;

    always_comb begin
        value = '0;
        if (in_code[6:4] == 3'd0)
            value = {7'd0, in_code[3:0]};
        else
            value = {6'd0, 1'b1, in_code[3:0]} << (in_code[6:4] - 3'd1);
    end

    // A saturated acc keeps producing a carry, so it stays pinned at max.
    assign sum_ext  = {1'b0, acc} + {{(SUM_W-10){1'b0}}, value};
    assign carry    = sum_ext[SUM_W];
    assign acc_next = carry ? '1 : sum_ext[SUM_W-1:0];
    assign ovf_next = ovf | carry;
    assign cnt_next = cnt + 9'd1;
    assign accept   = in_valid & in_ready;
    assign close    = accept ? ((cnt_next == LAST) | flush)
                             : (flush & (cnt != 9'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        ovf <= ovf_next;
                    end
                    if (close) begin
                        out_sum   <= accept ? acc_next : acc;
                        out_count <= accept ? cnt_next : cnt;
                        out_ovf   <= accept ? ovf_next : ovf;
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
